// File: rtl/file_seq_pkg.sv
// Shared definitions for the file command front-end: op codes, FSM states
// and path-length limits.
package file_seq_pkg;

  localparam int MAX_NAME   = 1022;
  localparam int NAME_CNT_W = 10;

  typedef enum logic [1:0] {
    OP_OPEN   = 2'd0,
    OP_READ   = 2'd1,
    OP_WRITE  = 2'd2,
    OP_DELETE = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GATHER,
    ST_EMIT,
    ST_TERM,
    ST_ISSUE,
    ST_RDWAIT,
    ST_RSP
  } state_t;

endpackage

// File: rtl/name_packer.sv
// Packs path bytes MSB-first into 32-bit words and tracks length and
// zero-byte errors; once the name has ended, further bytes are swallowed.
module name_packer
  import file_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  input  logic        i_last,
  output logic [31:0] o_word,
  output logic        o_emit,
  output logic        o_need_term,
  output logic        o_discarding,
  output logic        o_err
);

  logic [31:0]           r_word;
  logic [1:0]            r_lane;
  logic [NAME_CNT_W-1:0] r_count;
  logic                  r_discard;
  logic                  r_err;

  logic [31:0]           w_word;
  logic [NAME_CNT_W-1:0] w_count_inc;
  logic                  w_is_zero;
  logic                  w_end_name;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_word = r_word;
    case (r_lane)
      2'd0:    w_word[31:24] = i_byte;
      2'd1:    w_word[23:16] = i_byte;
      2'd2:    w_word[15:8]  = i_byte;
      default: w_word[7:0]   = i_byte;
    endcase
  end

  assign w_count_inc = r_count + 1'b1;
  assign w_is_zero   = (i_byte == 8'd0);
  // The name ends early on a NUL byte or when the length limit is reached.
  assign w_end_name  = w_is_zero || (w_count_inc == NAME_CNT_W'(MAX_NAME));

  assign o_word       = w_word;
  assign o_emit       = i_accept && !r_discard &&
                        ((r_lane == 2'd3) || i_last || w_end_name);
  // A word whose last lane is non-zero carries no terminator of its own.
  assign o_need_term  = (w_word[7:0] != 8'd0);
  assign o_discarding = r_discard;
  assign o_err        = r_err || (i_accept && (r_discard || w_is_zero));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word    <= '0;
      r_lane    <= '0;
      r_count   <= '0;
      r_discard <= 1'b0;
      r_err     <= 1'b0;
    end else if (i_clear) begin
      r_word    <= '0;
      r_lane    <= '0;
      r_count   <= '0;
      r_discard <= 1'b0;
      r_err     <= 1'b0;
    end else if (i_accept) begin
      r_err <= o_err;
      if (!r_discard) begin
        r_count <= w_count_inc;
        if (o_emit) begin
          r_word <= '0;
          r_lane <= '0;
        end else begin
          r_word <= w_word;
          r_lane <= r_lane + 1'b1;
        end
        if (w_end_name && !i_last) r_discard <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/file_port_sequencer.sv
// Command front-end for the filesystem: sequences OPEN path words and
// READ/WRITE/DELETE strobes, one command in flight, one response each.
module file_port_sequencer
  import file_seq_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic        name_valid,
  output logic        name_ready,
  input  logic [7:0]  name_byte,
  input  logic        name_last,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] fs_filename,
  output logic [31:0] fs_address,
  output logic [31:0] fs_data,
  output logic        fs_rden,
  output logic        fs_wren,
  output logic        fs_del,
  input  logic [31:0] fs_q
);

  state_t      r_state, w_state_next;
  op_t         r_op, w_op_next;
  logic [31:0] r_addr, w_addr_next;
  logic [31:0] r_wdata, w_wdata_next;
  logic        r_more, w_more_next;
  logic        r_need_term, w_need_term_next;

  logic        r_cmd_ready, r_name_ready, r_rsp_valid, r_rsp_err;
  logic [31:0] r_rsp_data, r_fs_filename, r_fs_address, r_fs_data;
  logic        r_fs_rden, r_fs_wren, r_fs_del;

  logic        w_cmd_ready_next, w_name_ready_next, w_rsp_valid_next, w_rsp_err_next;
  logic [31:0] w_rsp_data_next, w_filename_next, w_fs_address_next, w_fs_data_next;
  logic        w_fs_rden_next, w_fs_wren_next, w_fs_del_next, w_issue_next;

  logic        w_cmd_fire, w_name_fire, w_rsp_fire;
  logic [31:0] w_pk_word;
  logic        w_pk_emit, w_pk_need_term, w_pk_discarding, w_pk_err;

  assign w_cmd_fire  = cmd_valid && r_cmd_ready;
  assign w_name_fire = name_valid && r_name_ready && (r_state == ST_GATHER);
  assign w_rsp_fire  = r_rsp_valid && rsp_ready;

  name_packer u_name_packer (
    .clk          (CLOCK_50),
    .rst_n        (reset_n),
    .i_clear      (w_cmd_fire),
    .i_accept     (w_name_fire),
    .i_byte       (name_byte),
    .i_last       (name_last),
    .o_word       (w_pk_word),
    .o_emit       (w_pk_emit),
    .o_need_term  (w_pk_need_term),
    .o_discarding (w_pk_discarding),
    .o_err        (w_pk_err)
  );

  always_comb begin
    w_state_next     = r_state;
    w_op_next        = r_op;
    w_addr_next      = r_addr;
    w_wdata_next     = r_wdata;
    w_more_next      = r_more;
    w_need_term_next = r_need_term;
    w_filename_next  = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_cmd_fire) begin
          w_op_next        = op_t'(cmd_op);
          w_addr_next      = cmd_addr;
          w_wdata_next     = cmd_wdata;
          w_more_next      = 1'b0;
          w_need_term_next = 1'b0;
          w_state_next     = (op_t'(cmd_op) == OP_OPEN) ? ST_GATHER : ST_ISSUE;
        end
      end
      ST_GATHER: begin
        if (w_name_fire) begin
          if (w_pk_discarding) begin
            if (name_last) w_state_next = r_need_term ? ST_TERM : ST_RSP;
          end else if (w_pk_emit) begin
            w_filename_next  = w_pk_word;
            w_more_next      = !name_last;
            w_need_term_next = w_pk_need_term;
            w_state_next     = ST_EMIT;
          end
        end
      end
      ST_EMIT:   w_state_next = r_more ? ST_GATHER : (r_need_term ? ST_TERM : ST_RSP);
      ST_TERM:   w_state_next = ST_RSP;
      ST_ISSUE:  w_state_next = (r_op == OP_READ) ? ST_RDWAIT : ST_RSP;
      ST_RDWAIT: w_state_next = ST_RSP;
      ST_RSP:    if (w_rsp_fire) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase

    // Every output is registered, so it is derived from where the FSM is going.
    w_cmd_ready_next  = (w_state_next == ST_IDLE);
    w_name_ready_next = (w_state_next == ST_GATHER);
    w_issue_next      = (w_state_next == ST_ISSUE);
    w_fs_rden_next    = w_issue_next && (w_op_next == OP_READ);
    w_fs_wren_next    = w_issue_next && (w_op_next == OP_WRITE);
    w_fs_del_next     = w_issue_next && (w_op_next == OP_DELETE);
    w_fs_address_next = w_issue_next ? w_addr_next  : '0;
    w_fs_data_next    = w_issue_next ? w_wdata_next : '0;
    w_rsp_valid_next  = (w_state_next == ST_RSP);

    if (r_state == ST_RDWAIT)
      w_rsp_data_next = fs_q;
    else if ((r_state == ST_RSP) && (w_state_next == ST_RSP))
      w_rsp_data_next = r_rsp_data;
    else
      w_rsp_data_next = '0;

    if (w_state_next != ST_RSP)
      w_rsp_err_next = 1'b0;
    else if (r_state == ST_RSP)
      w_rsp_err_next = r_rsp_err;
    else
      w_rsp_err_next = (r_op == OP_OPEN) && w_pk_err;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_op          <= OP_OPEN;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_more        <= 1'b0;
      r_need_term   <= 1'b0;
      r_cmd_ready   <= 1'b0;
      r_name_ready  <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_fs_filename <= '0;
      r_fs_address  <= '0;
      r_fs_data     <= '0;
      r_fs_rden     <= 1'b0;
      r_fs_wren     <= 1'b0;
      r_fs_del      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_op          <= w_op_next;
      r_addr        <= w_addr_next;
      r_wdata       <= w_wdata_next;
      r_more        <= w_more_next;
      r_need_term   <= w_need_term_next;
      r_cmd_ready   <= w_cmd_ready_next;
      r_name_ready  <= w_name_ready_next;
      r_rsp_valid   <= w_rsp_valid_next;
      r_rsp_data    <= w_rsp_data_next;
      r_rsp_err     <= w_rsp_err_next;
      r_fs_filename <= w_filename_next;
      r_fs_address  <= w_fs_address_next;
      r_fs_data     <= w_fs_data_next;
      r_fs_rden     <= w_fs_rden_next;
      r_fs_wren     <= w_fs_wren_next;
      r_fs_del      <= w_fs_del_next;
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign name_ready  = r_name_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;
  assign fs_filename = r_fs_filename;
  assign fs_address  = r_fs_address;
  assign fs_data     = r_fs_data;
  assign fs_rden     = r_fs_rden;
  assign fs_wren     = r_fs_wren;
  assign fs_del      = r_fs_del;

endmodule

// File: tb/tb_file_port_sequencer.sv
// Directed bench for file_port_sequencer with a small filesystem memory model
// and a monitor that records emitted name words and strobes.
module tb_file_port_sequencer;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        name_valid, name_ready, name_last;
  logic [7:0]  name_byte;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic [31:0] fs_filename, fs_address, fs_data, fs_q;
  logic        fs_rden, fs_wren, fs_del;

  int errors = 0;
  int checks = 0;
  int accepted;
  int del_cnt  = 0;
  int rden_cnt = 0;
  int wren_cnt = 0;
  logic [31:0] words[$];
  logic [31:0] mem [16];

  always #5 CLOCK_50 = ~CLOCK_50;

  file_port_sequencer dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .name_valid  (name_valid),
    .name_ready  (name_ready),
    .name_byte   (name_byte),
    .name_last   (name_last),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .fs_filename (fs_filename),
    .fs_address  (fs_address),
    .fs_data     (fs_data),
    .fs_rden     (fs_rden),
    .fs_wren     (fs_wren),
    .fs_del      (fs_del),
    .fs_q        (fs_q)
  );

  // Filesystem model: one-cycle read latency.
  always @(posedge CLOCK_50) begin
    if (fs_wren) mem[fs_address[3:0]] <= fs_data;
    if (fs_rden) fs_q <= mem[fs_address[3:0]];
  end

  always @(negedge CLOCK_50) begin
    if (reset_n) begin
      if (fs_filename != 32'd0) words.push_back(fs_filename);
      if (fs_del)  del_cnt++;
      if (fs_rden) rden_cnt++;
      if (fs_wren) wren_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_cmd_ready(input string tag);
    for (int i = 0; i < 10 && !cmd_ready; i++) tick();
    check(tag, 32'(cmd_ready), 32'd1);
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    for (int i = 0; i < budget && !rsp_valid; i++) tick();
    check(tag, 32'(rsp_valid), 32'd1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic feed_byte(input logic [7:0] b, input logic last);
    logic ok;
    ok = 1'b0;
    name_valid = 1'b1;
    name_byte  = b;
    name_last  = last;
    for (int i = 0; i < 8 && !ok; i++) begin
      ok = name_ready;
      tick();
    end
    if (ok) accepted++;
  endtask

  function automatic logic [7:0] long_byte(input int i);
    return 8'h61 + 8'(i % 26);
  endfunction

  initial begin
    int bad;
    int d0;
    logic [31:0] exp_word;

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_wdata = '0;
    name_valid = 1'b0; name_byte = '0; name_last = 1'b0; rsp_ready = 1'b0;
    repeat (3) tick();
    check("reset_ctl", 32'({cmd_ready, name_ready, rsp_valid, rsp_err, fs_rden, fs_wren, fs_del}), 32'd0);
    check("reset_data", rsp_data | fs_filename | fs_address | fs_data, 32'd0);
    reset_n = 1'b1;
    tick();
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // WRITE addr 5: strobe in N+1, response in N+2.
    issue(2'd2, 32'd5, 32'hDEADBEEF);
    check("wr_wren", 32'(fs_wren), 32'd1);
    check("wr_addr", fs_address, 32'd5);
    check("wr_data", fs_data, 32'hDEADBEEF);
    check("wr_other_strobes", 32'({fs_rden, fs_del, cmd_ready}), 32'd0);
    tick();
    check("wr_wren_drop", 32'(fs_wren), 32'd0);
    check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wr_rsp_data", rsp_data, 32'd0);
    finish_rsp();
    check("wr_rsp_done", 32'(rsp_valid), 32'd0);
    check("wr_back_idle", 32'(cmd_ready), 32'd1);

    // READ addr 5: rden in N+1, response with data in N+3.
    issue(2'd1, 32'd5, 32'd0);
    check("rd_rden", 32'(fs_rden), 32'd1);
    check("rd_addr", fs_address, 32'd5);
    tick();
    check("rd_not_yet", 32'(rsp_valid), 32'd0);
    tick();
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_data", rsp_data, 32'hDEADBEEF);
    finish_rsp();

    // OPEN "ab.t": full word, then explicit zero terminator, response at N+7.
    wait_cmd_ready("open4_ready");
    words.delete();
    issue(2'd0, 32'd0, 32'd0);
    check("open4_handshake", 32'({name_ready, cmd_ready}), 32'b10);
    name_valid = 1'b1;
    name_byte = "a"; tick();
    name_byte = "b"; tick();
    name_byte = "."; tick();
    name_byte = "t"; name_last = 1'b1; tick();
    name_valid = 1'b0; name_last = 1'b0;
    check("open4_word", fs_filename, 32'h61622E74);
    tick();
    check("open4_term", fs_filename, 32'd0);
    check("open4_term_norsp", 32'(rsp_valid), 32'd0);
    tick();
    check("open4_rsp", 32'({rsp_valid, rsp_err}), 32'b10);
    check("open4_word_count", 32'(words.size()), 32'd1);
    finish_rsp();

    // OPEN "x/y": single padded word, no extra zero word, response at N+5.
    wait_cmd_ready("open3_ready");
    words.delete();
    issue(2'd0, 32'd0, 32'd0);
    name_valid = 1'b1;
    name_byte = "x"; tick();
    name_byte = "/"; tick();
    name_byte = "y"; name_last = 1'b1; tick();
    name_valid = 1'b0; name_last = 1'b0;
    check("open3_word", fs_filename, 32'h782F7900);
    tick();
    check("open3_rsp", 32'({rsp_valid, rsp_err}), 32'b10);
    check("open3_no_zero_word", fs_filename, 32'd0);
    finish_rsp();

    // OPEN "q\0r": the NUL ends the name, 'r' is swallowed, error flagged.
    wait_cmd_ready("openz_ready");
    words.delete();
    accepted = 0;
    issue(2'd0, 32'd0, 32'd0);
    feed_byte("q", 1'b0);
    feed_byte(8'h00, 1'b0);
    feed_byte("r", 1'b1);
    name_valid = 1'b0; name_last = 1'b0;
    wait_rsp("openz_rsp", 10);
    check("openz_err", 32'(rsp_err), 32'd1);
    check("openz_accepted", 32'(accepted), 32'd3);
    check("openz_words", 32'(words.size()), 32'd1);
    if (words.size() > 0) check("openz_word", words[0], 32'h71000000);
    finish_rsp();

    // DELETE with rsp_ready held low for 5 cycles.
    wait_cmd_ready("del_ready");
    d0 = del_cnt;
    issue(2'd3, 32'd9, 32'd0);
    check("del_strobe", 32'({fs_del, cmd_ready}), 32'b10);
    tick();
    check("del_rsp_valid", 32'(rsp_valid), 32'd1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!rsp_valid || cmd_ready || fs_del || fs_rden || fs_wren || rsp_data != 0) bad++;
    end
    check("del_stall_hold", 32'(bad), 32'd0);
    check("del_single_pulse", 32'(del_cnt - d0), 32'd1);
    finish_rsp();
    check("del_rsp_done", 32'(rsp_valid), 32'd0);

    // OPEN with 1030 bytes: 1022 bytes reach fs_filename, the rest are discarded.
    wait_cmd_ready("long_ready");
    words.delete();
    accepted = 0;
    issue(2'd0, 32'd0, 32'd0);
    for (int i = 0; i < 1030; i++) feed_byte(long_byte(i), i == 1029);
    name_valid = 1'b0; name_last = 1'b0;
    wait_rsp("long_rsp", 10);
    check("long_err", 32'(rsp_err), 32'd1);
    check("long_accepted", 32'(accepted), 32'd1030);
    check("long_word_count", 32'(words.size()), 32'd256);
    bad = 0;
    for (int k = 0; k < 256 && k < words.size(); k++) begin
      if (k < 255)
        exp_word = {long_byte(4*k), long_byte(4*k+1), long_byte(4*k+2), long_byte(4*k+3)};
      else
        exp_word = {long_byte(1020), long_byte(1021), 16'h0000};
      if (words[k] !== exp_word) bad++;
    end
    check("long_word_values", 32'(bad), 32'd0);
    finish_rsp();

    // Asynchronous reset during GATHER after two bytes.
    wait_cmd_ready("rst_ready");
    issue(2'd0, 32'd0, 32'd0);
    feed_byte("m", 1'b0);
    feed_byte("n", 1'b0);
    name_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_ctl", 32'({cmd_ready, name_ready, rsp_valid, rsp_err, fs_rden, fs_wren, fs_del}), 32'd0);
    check("async_rst_data", rsp_data | fs_filename | fs_address | fs_data, 32'd0);
    tick();
    reset_n = 1'b1;
    wait_cmd_ready("post_rst_ready");
    issue(2'd1, 32'd5, 32'd0);
    check("post_rst_rden", 32'(fs_rden), 32'd1);
    tick();
    tick();
    check("post_rst_rsp", 32'({rsp_valid, rsp_err}), 32'b10);
    check("post_rst_data", rsp_data, 32'hDEADBEEF);
    finish_rsp();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
